// File: rtl/wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter. Grants one of NUM_SRC result producers per
//               cycle onto a registered register-file write port and PC port.
// Revision    : 1.0 - initial release
//==============================================================================
module wb_arbiter #(
   parameter int NUM_SRC  = 2,
   parameter int XLEN     = 32,
   parameter int RA_W     = 5,
   parameter int ARB_MODE = 0,
   parameter int CNT_W    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic [NUM_SRC-1:0]       src_ready,
   input  logic [NUM_SRC*RA_W-1:0]  src_rd,
   input  logic [NUM_SRC*XLEN-1:0]  src_value,
   input  logic [NUM_SRC-1:0]       src_pc_valid,
   input  logic [NUM_SRC*XLEN-1:0]  src_pc,
   output logic                     rf_we,
   output logic [RA_W-1:0]          rf_waddr,
   output logic [XLEN-1:0]          rf_wdata,
   output logic                     pc_we,
   output logic [XLEN-1:0]          pc_value,
   output logic [CNT_W-1:0]         retire_cnt
);

   localparam int c_PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] w_grant;
   logic [c_PTR_W-1:0] w_sel;
   logic [c_PTR_W-1:0] w_ptr_next;
   logic               w_accept;
   int                 w_idx;
   logic [RA_W-1:0]    w_rd;
   logic [XLEN-1:0]    w_value;
   logic [XLEN-1:0]    w_pc;
   logic               w_pc_valid;

   logic [c_PTR_W-1:0] r_rr_ptr;
   logic               r_rf_we;
   logic [RA_W-1:0]    r_rf_waddr;
   logic [XLEN-1:0]    r_rf_wdata;
   logic               r_pc_we;
   logic [XLEN-1:0]    r_pc_value;
   logic [CNT_W-1:0]   r_retire_cnt;

   // Search order starts at the rotating pointer in round-robin mode, at 0 otherwise.
   always_comb begin
      w_grant  = '0;
      w_sel    = '0;
      w_accept = 1'b0;
      w_idx    = 0;
      if (!stall) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = (ARB_MODE == 1) ? ((int'(r_rr_ptr) + k) % NUM_SRC) : k;
            if (!w_accept && src_valid[w_idx]) begin
               w_grant[w_idx] = 1'b1;
               w_sel          = c_PTR_W'(w_idx);
               w_accept       = 1'b1;
            end
         end
      end
   end

   assign src_ready  = w_grant;
   assign w_rd       = src_rd[w_sel*RA_W +: RA_W];
   assign w_value    = src_value[w_sel*XLEN +: XLEN];
   assign w_pc       = src_pc[w_sel*XLEN +: XLEN];
   assign w_pc_valid = src_pc_valid[w_sel];
   assign w_ptr_next = (w_sel == c_PTR_W'(NUM_SRC - 1)) ? '0 : w_sel + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr     <= '0;
         r_rf_we      <= 1'b0;
         r_rf_waddr   <= '0;
         r_rf_wdata   <= '0;
         r_pc_we      <= 1'b0;
         r_pc_value   <= '0;
         r_retire_cnt <= '0;
      end else if (w_accept) begin
         r_rr_ptr     <= w_ptr_next;
         // x0 writes retire normally but must never reach the register file.
         r_rf_we      <= (w_rd != '0);
         r_rf_waddr   <= w_rd;
         r_rf_wdata   <= w_value;
         r_pc_we      <= w_pc_valid;
         r_pc_value   <= w_pc;
         r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end else begin
         r_rf_we      <= 1'b0;
         r_pc_we      <= 1'b0;
      end
   end

   assign rf_we      = r_rf_we;
   assign rf_waddr   = r_rf_waddr;
   assign rf_wdata   = r_rf_wdata;
   assign pc_we      = r_pc_we;
   assign pc_value   = r_pc_value;
   assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_wb_arbiter
// Description : Scoreboard bench for wb_arbiter in fixed-priority (2 sources)
//               and round-robin (3 sources, 4-bit counter) configurations.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_wb_arbiter;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        pc_we;
      logic [31:0] pc;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // dut0: NUM_SRC 2, fixed priority
   logic        stall0 = 1'b0;
   logic [1:0]  v0 = '0, pcv0 = '0, rdy0;
   logic [9:0]  rd0 = '0;
   logic [63:0] val0 = '0, pc0 = '0;
   logic        rf_we0, pc_we0;
   logic [4:0]  waddr0;
   logic [31:0] wdata0, pcval0, cnt0;

   // dut1: NUM_SRC 3, round-robin, CNT_W 4
   logic        stall1 = 1'b0;
   logic [2:0]  v1 = '0, pcv1 = '0, rdy1;
   logic [14:0] rd1 = '0;
   logic [95:0] val1 = '0, pc1 = '0;
   logic        rf_we1, pc_we1;
   logic [4:0]  waddr1;
   logic [31:0] wdata1, pcval1;
   logic [3:0]  cnt1;

   wb_arbiter #(.NUM_SRC(2), .XLEN(32), .RA_W(5), .ARB_MODE(0), .CNT_W(32)) dut0 (
      .clk(clk), .rst_n(rst_n), .stall(stall0), .src_valid(v0), .src_ready(rdy0),
      .src_rd(rd0), .src_value(val0), .src_pc_valid(pcv0), .src_pc(pc0),
      .rf_we(rf_we0), .rf_waddr(waddr0), .rf_wdata(wdata0), .pc_we(pc_we0),
      .pc_value(pcval0), .retire_cnt(cnt0));

   wb_arbiter #(.NUM_SRC(3), .XLEN(32), .RA_W(5), .ARB_MODE(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .stall(stall1), .src_valid(v1), .src_ready(rdy1),
      .src_rd(rd1), .src_value(val1), .src_pc_valid(pcv1), .src_pc(pc1),
      .rf_we(rf_we1), .rf_waddr(waddr1), .rf_wdata(wdata1), .pc_we(pc_we1),
      .pc_value(pcval1), .retire_cnt(cnt1));

   int          checks = 0;
   int          errors = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] ecnt0 = '0;
   logic [3:0]  ecnt1 = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input int s);
      exp_t e;
      ecnt0   = ecnt0 + 1;
      e.rf_we = (rd0[s*5 +: 5] != 5'd0);
      e.waddr = rd0[s*5 +: 5];
      e.wdata = val0[s*32 +: 32];
      e.pc_we = pcv0[s];
      e.pc    = pc0[s*32 +: 32];
      e.cnt   = ecnt0;
      q0.push_back(e);
   endtask

   task automatic push1(input int s);
      exp_t e;
      ecnt1   = ecnt1 + 4'd1;
      e.rf_we = (rd1[s*5 +: 5] != 5'd0);
      e.waddr = rd1[s*5 +: 5];
      e.wdata = val1[s*32 +: 32];
      e.pc_we = pcv1[s];
      e.pc    = pc1[s*32 +: 32];
      e.cnt   = {28'd0, ecnt1};
      q1.push_back(e);
   endtask

   // Asserts reset away from the clock edge, checks the asynchronous clear,
   // then releases and checks the idle state.
   task automatic do_reset(input string nm);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({nm, "_async0"}, {rf_we0, pc_we0, waddr0, wdata0, pcval0, cnt0}, '0);
      chk({nm, "_async1"}, {rf_we1, pc_we1, waddr1, wdata1, pcval1, cnt1}, '0);
      q0.delete();
      q1.delete();
      ecnt0 = '0;
      ecnt1 = '0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      chk({nm, "_idle0"}, {rf_we0, pc_we0, cnt0}, '0);
      chk({nm, "_idle1"}, {rf_we1, pc_we1, cnt1}, '0);
   endtask

   logic [31:0] last0 = '0;
   logic [3:0]  last1 = '0;

   always @(negedge clk) begin
      exp_t a;
      if (!rst_n) begin
         last0 = '0;
      end else if (rf_we0 || pc_we0 || (cnt0 != last0)) begin
         last0 = cnt0;
         a = {rf_we0, waddr0, wdata0, pc_we0, pcval0, cnt0};
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut0_unexpected_out actual=%0h required=none", a);
         end else begin
            chk("dut0_out", a, q0.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      exp_t a;
      if (!rst_n) begin
         last1 = '0;
      end else if (rf_we1 || pc_we1 || (cnt1 != last1)) begin
         last1 = cnt1;
         a = {rf_we1, waddr1, wdata1, pc_we1, pcval1, 28'd0, cnt1};
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut1_unexpected_out actual=%0h required=none", a);
         end else begin
            chk("dut1_out", a, q1.pop_front());
         end
      end
   end

   initial begin
      int rr_exp[6] = '{0, 1, 2, 0, 1, 2};
      logic [2:0] one3;
      one3 = 3'b001;

      do_reset("rst_init");

      // Fixed priority: both valid, src0 first then src1
      v0 = 2'b11; rd0 = {5'd7, 5'd3}; val0 = {32'h0000_5555, 32'hAAAA_0000};
      #1 chk("fp_ready_both", rdy0, 2'b01); push0(0);
      step();
      v0 = 2'b10;
      #1 chk("fp_ready_src1", rdy0, 2'b10); push0(1);
      step();
      v0 = 2'b00;
      chk("fp_cnt", cnt0, 32'd2);
      #1 chk("fp_ready_idle", rdy0, 2'b00);

      // x0 write carrying a PC update
      v0 = 2'b10; rd0 = {5'd0, 5'd3}; val0 = {32'h0000_1234, 32'h0};
      pcv0 = 2'b10; pc0 = {32'h8000_0010, 32'h0};
      #1 chk("x0_ready", rdy0, 2'b10); push0(1);
      step();
      v0 = 2'b00; pcv0 = 2'b00;
      chk("x0_outputs", {rf_we0, pc_we0, pcval0, cnt0}, {1'b0, 1'b1, 32'h8000_0010, 32'd3});

      // Stall holds off a waiting source
      stall0 = 1'b1; v0 = 2'b01; rd0 = {5'd0, 5'd12}; val0 = {32'h0, 32'hDEAD_0001};
      repeat (3) begin
         #1 chk("stall_ready", rdy0, 2'b00);
         step();
         chk("stall_rf_we", rf_we0, 1'b0);
         chk("stall_cnt", cnt0, 32'd3);
      end
      stall0 = 1'b0;
      #1 chk("stall_release_ready", rdy0, 2'b01); push0(0);
      step();
      v0 = 2'b00;
      chk("stall_release_we", rf_we0, 1'b1);

      // Reset while a write is on the outputs
      step();
      v0 = 2'b01;
      #1 chk("mid_ready", rdy0, 2'b01); push0(0);
      step();
      v0 = 2'b00;
      chk("mid_we_before_rst", rf_we0, 1'b1);
      do_reset("rst_mid");

      // Round-robin with all three sources valid
      rd1 = {5'd9, 5'd8, 5'd6};
      val1 = {32'h2222_2222, 32'h1111_1111, 32'h0BAD_0000};
      pcv1 = 3'b100; pc1 = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
      v1 = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1 chk("rr_ready", rdy1, one3 << rr_exp[i]); push1(rr_exp[i]);
         step();
      end
      v1 = 3'b000;
      chk("rr_cnt", cnt1, 4'd6);

      // Pointer at 0 skips src0; then pointer at 2 wraps past src2 to src0
      v1 = 3'b110;
      #1 chk("rr_skip", rdy1, 3'b010); push1(1);
      step();
      v1 = 3'b011;
      #1 chk("rr_wrap", rdy1, 3'b001); push1(0);
      step();
      v1 = 3'b000;

      // Counter wrap with a 4-bit counter
      do_reset("rst_wrap");
      v1 = 3'b001;
      repeat (17) begin
         #1 chk("wrap_ready", rdy1, 3'b001); push1(0);
         step();
      end
      v1 = 3'b000;
      chk("wrap_cnt", cnt1, 4'd1);

      repeat (3) step();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised writeback stage that arbitrates up to NUM_SRC result producers (exec, load, CSR, …) onto one register-file write port and one PC-update port. Each source presents a valid/ready request with destination register, value and optional PC update; one request is granted per cycle, selected by fixed-priority or round-robin mode. The granted request is registered before it reaches the register file and PC register. A retire counter records every accepted request.

## Interface
Parameters:
- NUM_SRC, 2: number of source channels, 2..8.
- XLEN, 32: data and PC width.
- RA_W, 5: register address width.
- ARB_MODE, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- CNT_W, 32: retire counter width.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- stall  in  1  when 1: no grants; outputs of the next cycle deassert.
- src_valid  in  NUM_SRC  per-source request.
- src_ready  out  NUM_SRC  one-hot grant (combinational), zero when stall = 1.
- src_rd  in  NUM_SRC*RA_W  destination register per source (packed, source i at [i*RA_W +: RA_W]).
- src_value  in  NUM_SRC*XLEN  writeback value per source.
- src_pc_valid  in  NUM_SRC  source also updates the PC.
- src_pc  in  NUM_SRC*XLEN  next PC per source.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RA_W  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- pc_we  out  1  PC write enable.
- pc_value  out  XLEN  next PC value.
- retire_cnt  out  CNT_W  count of accepted requests.

## Operation
- Grant computation (combinational):
  - When stall = 0 and any src_valid is set, exactly one src_ready bit is set.
  - ARB_MODE 0: the lowest-index valid source wins.
  - ARB_MODE 1: the search starts at rr_ptr and wraps modulo NUM_SRC; the first valid source wins.
- Accept condition: src_valid[i] & src_ready[i]. A source holds its valid and payload until it is accepted.
- rr_ptr update:
  - On accept of source i, rr_ptr ← (i+1) mod NUM_SRC.
  - Unchanged on idle or stall.
  - Unused in mode 0.
- Output register, loaded on an accept of source i:
  - rf_we ← (src_rd_i != 0). Writes to x0 are accepted and counted but never write.
  - rf_waddr ← src_rd_i.
  - rf_wdata ← src_value_i.
  - pc_we ← src_pc_valid_i.
  - pc_value ← src_pc_i.
- Output register with no accept (idle or stall):
  - rf_we ← 0 and pc_we ← 0.
  - rf_waddr, rf_wdata and pc_value hold their last values.
- PC update and register write are independent. A source may update the PC with rd = 0, e.g. a jump with no link.
- retire_cnt increments by 1 per accept and wraps modulo 2^CNT_W.
- Reset values: rf_we = 0, pc_we = 0, rf_waddr = 0, rf_wdata = 0, pc_value = 0, retire_cnt = 0, rr_ptr = 0.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). Requests in flight are not retained; sources re-present them after reset.

## Timing
- Latency from accept edge to rf_we / pc_we: 1 cycle. The write is visible on outputs during the cycle after the accept.
- Throughput: one accept per cycle, sustained.
- src_ready depends combinationally on src_valid, stall and rr_ptr. It does not depend on src_ready or any other output, so there is no combinational loop.
- stall takes effect in the same cycle: src_ready = 0 in that cycle, and rf_we / pc_we are 0 in the following cycle.
- Simultaneous requests:
  - Losers see src_ready = 0 and must hold their requests.
  - In mode 1, with N sources continuously valid, each is granted within N cycles (no starvation).
- retire_cnt updates on the same edge that loads the output register.

## Test plan
- **Reset.** Assert rst_n = 0 mid-stream with rf_we = 1 → all outputs 0 immediately. After release with no valid: rf_we = pc_we = 0 and retire_cnt = 0.
- **Fixed priority (ARB_MODE 0, NUM_SRC 2).** Both valid, src0 (rd = 3, value = 0xAAAA0000), src1 (rd = 7, value = 0x5555) → src_ready = 01. Next cycle: rf_we = 1, rf_waddr = 3, rf_wdata = 0xAAAA0000. src1 is accepted in the following cycle; retire_cnt = 2.
- **Round-robin (ARB_MODE 1, NUM_SRC 3).** All three valid continuously for 6 cycles → grant order 0, 1, 2, 0, 1, 2; retire_cnt = 6.
- **x0 write with PC update.** src1 presents rd = 0, value = 0x1234, pc_valid = 1, pc = 0x80000010 → next cycle rf_we = 0, pc_we = 1, pc_value = 0x80000010; retire_cnt increments.
- **Stall.** src0 valid with stall = 1 for 3 cycles → src_ready = 0 throughout, and rf_we = 0, retire_cnt unchanged. Stall drops → accept in that cycle, rf_we = 1 in the next.
- **Counter wrap (CNT_W = 4).** 17 back-to-back accepts → retire_cnt reads 1.
